elink_rx_deframer: RTL and testbench

- Receive-side protocol decoder for the elink. Consumes the deserialized byte stream, one byte per clock with frame qualifier, and reassembles emesh write packets.
- Presents packets on the rxwr_access/rxwr_packet/rxwr_wait interface through an internal FIFO.
- Drives rxo_wr_wait back to the far-end transmitter for flow control. Sits between the rx IO/deserializer and the rx write-channel consumer.

---
 rtl/elink_pkg.sv | 33 +++
 rtl/elink_rx_fifo.sv | 44 ++++
 rtl/elink_rx_deframer.sv | 167 ++++++++++++++++
 tb/tb_elink_rx_deframer.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/elink_pkg.sv
// Shared elink definitions: emesh packet layout, command-byte fields and receive FSM states.
package elink_pkg;

    localparam int PW           = 104;
    localparam int ADDR_W       = 32;

    localparam int WRITE_LSB    = 0;
    localparam int DATAMODE_LSB = 1;
    localparam int DATAMODE_W   = 2;
    localparam int CTRLMODE_LSB = 3;
    localparam int CTRLMODE_W   = 4;
    localparam int DSTADDR_LSB  = 7;
    localparam int DATA_LSB     = 39;
    localparam int SRCADDR_LSB  = 71;

    // Command byte: [7]=write, [6:5]=datamode, [4:1]=ctrlmode, [0]=burst
    localparam int CMD_WRITE_BIT    = 7;
    localparam int CMD_DATAMODE_LSB = 5;
    localparam int CMD_CTRLMODE_LSB = 1;
    localparam int CMD_BURST_BIT    = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_SRC  = 2'd3
    } rx_state_e;

    function automatic logic [ADDR_W-1:0] burst_stride(input logic [DATAMODE_W-1:0] datamode);
        return ADDR_W'(1) << datamode;
    endfunction

endpackage

// File: rtl/elink_rx_fifo.sv
// First-word-fall-through synchronous FIFO; pointers carry a wrap bit so count needs no extra state.
module elink_rx_fifo #(
    parameter int W     = 104,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     resetb,
    input  logic                     wr_en,
    input  logic [W-1:0]             wr_data,
    input  logic                     rd_en,
    output logic [W-1:0]             rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]  wr_ptr, rd_ptr;
    logic [W-1:0] mem [DEPTH];
    logic         do_wr, do_rd;

    assign count   = wr_ptr - rd_ptr;
    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_rd   = rd_en & ~empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign do_wr   = wr_en & (~full | do_rd);
    assign rd_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/elink_rx_deframer.sv
// elink receive deframer: rebuilds emesh write packets from the framed byte stream
// and queues them for the rxwr consumer, with backpressure to the far-end transmitter.
module elink_rx_deframer #(
    parameter int PW          = elink_pkg::PW,
    parameter int DEPTH       = 4,
    parameter int WAIT_MARGIN = 2
) (
    input  logic          clk,
    input  logic          resetb,
    input  logic          rxi_frame,
    input  logic [7:0]    rxi_data,
    output logic          rxo_wr_wait,
    output logic          rxwr_access,
    output logic [PW-1:0] rxwr_packet,
    input  logic          rxwr_wait,
    output logic          rx_err_abort,
    output logic          rx_err_ovf
);
    import elink_pkg::*;

    localparam int CW = $clog2(DEPTH) + 1;

    rx_state_e               state, state_next;
    logic [1:0]              byte_cnt, byte_cnt_next;
    logic                    latch_cmd, shift_en, beat_done, abort;
    logic                    beat_open;

    logic                    write_q, burst_q;
    logic [DATAMODE_W-1:0]   datamode_q;
    logic [CTRLMODE_W-1:0]   ctrlmode_q;
    logic [ADDR_W-1:0]       dstaddr_q, data_q, srcaddr_q, srcaddr_full;
    logic [PW-1:0]           pkt_next, pkt_q;
    logic                    push_q;

    logic [PW-1:0]           fifo_head;
    logic [CW-1:0]           fifo_count, count_next;
    logic                    fifo_full, fifo_empty, pop, push_ok;

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state    <= ST_IDLE;
            byte_cnt <= 2'd0;
        end else begin
            state    <= state_next;
            byte_cnt <= byte_cnt_next;
        end
    end

    always_comb begin
        state_next    = state;
        byte_cnt_next = byte_cnt;
        latch_cmd     = 1'b0;
        shift_en      = 1'b0;
        beat_done     = 1'b0;
        abort         = 1'b0;
        if (state == ST_IDLE) begin
            if (rxi_frame) begin
                latch_cmd     = 1'b1;
                byte_cnt_next = 2'd0;
                state_next    = ST_ADDR;
            end
        end else if (rxi_frame) begin
            shift_en      = 1'b1;
            byte_cnt_next = byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
                case (state)
                    ST_ADDR: state_next = ST_DATA;
                    ST_DATA: state_next = ST_SRC;
                    default: begin
                        beat_done  = 1'b1;
                        state_next = burst_q ? ST_DATA : ST_IDLE;
                    end
                endcase
            end
        end else begin
            // Frame ending between burst beats is a normal end of transaction.
            state_next    = ST_IDLE;
            byte_cnt_next = 2'd0;
            abort         = !(state == ST_DATA && byte_cnt == 2'd0 && beat_open);
        end
    end

    assign srcaddr_full = {srcaddr_q[ADDR_W-9:0], rxi_data};

    always_comb begin
        pkt_next = '0;
        pkt_next[WRITE_LSB]                     = write_q;
        pkt_next[DATAMODE_LSB +: DATAMODE_W]    = datamode_q;
        pkt_next[CTRLMODE_LSB +: CTRLMODE_W]    = ctrlmode_q;
        pkt_next[DSTADDR_LSB +: ADDR_W]         = dstaddr_q;
        pkt_next[DATA_LSB +: ADDR_W]            = data_q;
        pkt_next[SRCADDR_LSB +: ADDR_W]         = srcaddr_full;
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            write_q    <= 1'b0;
            burst_q    <= 1'b0;
            datamode_q <= '0;
            ctrlmode_q <= '0;
            dstaddr_q  <= '0;
            data_q     <= '0;
            srcaddr_q  <= '0;
            pkt_q      <= '0;
            push_q     <= 1'b0;
            beat_open  <= 1'b0;
        end else begin
            push_q <= beat_done;
            if (latch_cmd) begin
                write_q    <= rxi_data[CMD_WRITE_BIT];
                datamode_q <= rxi_data[CMD_DATAMODE_LSB +: DATAMODE_W];
                ctrlmode_q <= rxi_data[CMD_CTRLMODE_LSB +: CTRLMODE_W];
                burst_q    <= rxi_data[CMD_BURST_BIT];
                beat_open  <= 1'b0;
            end
            if (shift_en) begin
                case (state)
                    ST_ADDR: dstaddr_q <= {dstaddr_q[ADDR_W-9:0], rxi_data};
                    ST_DATA: data_q    <= {data_q[ADDR_W-9:0], rxi_data};
                    ST_SRC:  srcaddr_q <= srcaddr_full;
                    default: ;
                endcase
            end
            if (beat_done) begin
                pkt_q     <= pkt_next;
                beat_open <= 1'b1;
                if (burst_q) dstaddr_q <= dstaddr_q + burst_stride(datamode_q);
            end
        end
    end

    elink_rx_fifo #(
        .W     (PW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .resetb  (resetb),
        .wr_en   (push_q),
        .wr_data (pkt_q),
        .rd_en   (pop),
        .rd_data (fifo_head),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // rxwr_access is valid; a packet transfers in any cycle with rxwr_access=1 and
    // rxwr_wait=0, and the head entry stays stable on rxwr_packet until it does.
    assign rxwr_access = ~fifo_empty;
    assign rxwr_packet = fifo_empty ? '0 : fifo_head;
    assign pop         = rxwr_access & ~rxwr_wait;
    assign push_ok     = push_q & (~fifo_full | pop);
    assign count_next  = fifo_count + CW'(push_ok) - CW'(pop);

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            rxo_wr_wait  <= 1'b0;
            rx_err_abort <= 1'b0;
            rx_err_ovf   <= 1'b0;
        end else begin
            rxo_wr_wait  <= ((DEPTH - int'(count_next)) <= WAIT_MARGIN);
            rx_err_abort <= abort;
            rx_err_ovf   <= push_q & fifo_full & ~pop;
        end
    end

endmodule

// File: tb/tb_elink_rx_deframer.sv
// Directed bench for elink_rx_deframer: single, burst, abort, backpressure, push/pop-on-full and reset.
module tb_elink_rx_deframer;

    localparam int PW = 104;

    logic          clk       = 1'b0;
    logic          resetb    = 1'b0;
    logic          rxi_frame = 1'b0;
    logic [7:0]    rxi_data  = 8'h00;
    logic          rxwr_wait = 1'b0;
    logic          rxo_wr_wait, rxwr_access, rx_err_abort, rx_err_ovf;
    logic [PW-1:0] rxwr_packet;

    int n_cmp     = 0;
    int n_err     = 0;
    int abort_cnt = 0;
    int ovf_cnt   = 0;

    always #5 clk = ~clk;

    elink_rx_deframer #(
        .PW          (PW),
        .DEPTH       (4),
        .WAIT_MARGIN (2)
    ) dut (
        .clk          (clk),
        .resetb       (resetb),
        .rxi_frame    (rxi_frame),
        .rxi_data     (rxi_data),
        .rxo_wr_wait  (rxo_wr_wait),
        .rxwr_access  (rxwr_access),
        .rxwr_packet  (rxwr_packet),
        .rxwr_wait    (rxwr_wait),
        .rx_err_abort (rx_err_abort),
        .rx_err_ovf   (rx_err_ovf)
    );

    always @(posedge clk) begin
        if (rx_err_abort) abort_cnt++;
        if (rx_err_ovf)   ovf_cnt++;
    end

    task automatic check(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input logic f, input logic [7:0] d);
        rxi_frame = f;
        rxi_data  = d;
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 3; i >= 0; i--) tick(1'b1, w[8*i +: 8]);
    endtask

    task automatic send_pkt(input logic [7:0] cmd, input logic [31:0] dst,
                            input logic [31:0] data, input logic [31:0] src);
        tick(1'b1, cmd);
        send_word(dst);
        send_word(data);
        send_word(src);
    endtask

    function automatic logic [PW-1:0] mk_pkt(input logic w, input logic [1:0] dm, input logic [3:0] cm,
                                             input logic [31:0] dst, input logic [31:0] data,
                                             input logic [31:0] src);
        return {1'b0, src, data, dst, cm, dm, w};
    endfunction

    task automatic pop_check(input string tag, input logic [PW-1:0] exp);
        check({tag, "_access"}, rxwr_access, 1);
        check(tag, rxwr_packet, exp);
        rxwr_wait = 1'b0;
        tick(1'b0, 8'h00);
        rxwr_wait = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        tick(1'b0, 8'h00);
        tick(1'b0, 8'h00);
        check("rst_access", rxwr_access, 0);
        check("rst_packet", rxwr_packet, 0);
        check("rst_wr_wait", rxo_wr_wait, 0);
        check("rst_abort", rx_err_abort, 0);
        check("rst_ovf", rx_err_ovf, 0);
        check("rst_count", dut.fifo_count, 0);
        resetb = 1'b1;
        tick(1'b0, 8'h00);

        // Single write: packet visible two cycles after the last byte, for one cycle
        rxwr_wait = 1'b0;
        send_pkt(8'h84, 32'h8080_1000, 32'hDEAD_BEEF, 32'h0000_0000);
        check("single_early", rxwr_access, 0);
        tick(1'b0, 8'h00);
        check("single_access", rxwr_access, 1);
        check("single_packet", rxwr_packet, mk_pkt(1'b1, 2'd0, 4'd2, 32'h8080_1000, 32'hDEAD_BEEF, 32'h0));
        tick(1'b0, 8'h00);
        check("single_drained", rxwr_access, 0);

        // Burst of three beats, datamode=2 so dstaddr steps by 4
        rxwr_wait = 1'b1;
        tick(1'b1, 8'hC1);
        send_word(32'h0000_0100);
        send_word(32'h1111_1111); send_word(32'hA000_0001);
        send_word(32'h2222_2222); send_word(32'hA000_0002);
        send_word(32'h3333_3333); send_word(32'hA000_0003);
        tick(1'b0, 8'h00);
        tick(1'b0, 8'h00);
        check("burst_count", dut.fifo_count, 3);
        check("burst_wr_wait", rxo_wr_wait, 1);
        check("burst_no_abort", abort_cnt, 0);
        pop_check("burst_pkt0", mk_pkt(1'b1, 2'd2, 4'd0, 32'h0000_0100, 32'h1111_1111, 32'hA000_0001));
        pop_check("burst_pkt1", mk_pkt(1'b1, 2'd2, 4'd0, 32'h0000_0104, 32'h2222_2222, 32'hA000_0002));
        pop_check("burst_pkt2", mk_pkt(1'b1, 2'd2, 4'd0, 32'h0000_0108, 32'h3333_3333, 32'hA000_0003));
        check("burst_empty", rxwr_access, 0);

        // Abort after two data bytes, then a clean transaction
        rxwr_wait = 1'b0;
        tick(1'b1, 8'h80);
        send_word(32'h0000_3000);
        tick(1'b1, 8'hAA);
        tick(1'b1, 8'hBB);
        tick(1'b0, 8'h00);
        check("abort_pulse", rx_err_abort, 1);
        tick(1'b0, 8'h00);
        check("abort_pulse_end", rx_err_abort, 0);
        check("abort_once", abort_cnt, 1);
        tick(1'b0, 8'h00);
        check("abort_no_packet", rxwr_access, 0);
        send_pkt(8'h86, 32'h0000_2000, 32'h1234_5678, 32'h0000_CAFE);
        tick(1'b0, 8'h00);
        check("post_abort_access", rxwr_access, 1);
        check("post_abort_packet", rxwr_packet, mk_pkt(1'b1, 2'd0, 4'd3, 32'h0000_2000, 32'h1234_5678, 32'h0000_CAFE));
        tick(1'b0, 8'h00);

        // Backpressure: fill four entries, fifth overflows
        rxwr_wait = 1'b1;
        for (int i = 0; i < 4; i++) begin
            send_pkt(8'h80, 32'h1000 + 32'(16*i), 32'hA5A5_0000 + 32'(i), 32'h5A5A_0000 + 32'(i));
            tick(1'b0, 8'h00);
            check("bp_count", dut.fifo_count, i + 1);
            check("bp_wr_wait", rxo_wr_wait, (i >= 1));
        end
        send_pkt(8'h80, 32'h0000_9999, 32'h0000_9999, 32'h0000_9999);
        tick(1'b0, 8'h00);
        check("ovf_pulse", rx_err_ovf, 1);
        check("ovf_count", dut.fifo_count, 4);
        tick(1'b0, 8'h00);
        check("ovf_pulse_end", rx_err_ovf, 0);
        check("ovf_once", ovf_cnt, 1);
        for (int i = 0; i < 4; i++)
            pop_check("bp_drain", mk_pkt(1'b1, 2'd0, 4'd0, 32'h1000 + 32'(16*i),
                                         32'hA5A5_0000 + 32'(i), 32'h5A5A_0000 + 32'(i)));
        check("bp_drained", rxwr_access, 0);
        check("bp_wr_wait_low", rxo_wr_wait, 0);

        // Push into a full FIFO in the same cycle as a pop
        for (int i = 0; i < 4; i++) begin
            send_pkt(8'h80, 32'hB000_0000 + 32'(i), 32'hC000_0000 + 32'(i), 32'hD000_0000 + 32'(i));
            tick(1'b0, 8'h00);
        end
        check("pp_full", dut.fifo_count, 4);
        send_pkt(8'h80, 32'hB000_0004, 32'hC000_0004, 32'hD000_0004);
        rxwr_wait = 1'b0;
        tick(1'b0, 8'h00);
        rxwr_wait = 1'b1;
        check("pp_no_ovf", rx_err_ovf, 0);
        check("pp_count", dut.fifo_count, 4);
        tick(1'b0, 8'h00);
        check("pp_ovf_total", ovf_cnt, 1);
        for (int i = 1; i < 5; i++)
            pop_check("pp_drain", mk_pkt(1'b1, 2'd0, 4'd0, 32'hB000_0000 + 32'(i),
                                         32'hC000_0000 + 32'(i), 32'hD000_0000 + 32'(i)));
        check("pp_drained", rxwr_access, 0);

        // Asynchronous reset mid-SRC with two packets queued
        send_pkt(8'h80, 32'h0000_0001, 32'h0000_0002, 32'h0000_0003);
        tick(1'b0, 8'h00);
        send_pkt(8'h80, 32'h0000_0011, 32'h0000_0012, 32'h0000_0013);
        tick(1'b0, 8'h00);
        check("pre_rst_count", dut.fifo_count, 2);
        check("pre_rst_wr_wait", rxo_wr_wait, 1);
        tick(1'b1, 8'h80);
        send_word(32'h0000_0021);
        send_word(32'h0000_0022);
        tick(1'b1, 8'h11);
        tick(1'b1, 8'h22);
        #2;
        resetb = 1'b0;
        #1;
        check("arst_access", rxwr_access, 0);
        check("arst_packet", rxwr_packet, 0);
        check("arst_wr_wait", rxo_wr_wait, 0);
        check("arst_abort", rx_err_abort, 0);
        check("arst_ovf", rx_err_ovf, 0);
        check("arst_count", dut.fifo_count, 0);
        rxi_frame = 1'b0;
        @(posedge clk);
        #1;
        resetb    = 1'b1;
        rxwr_wait = 1'b0;
        send_pkt(8'h84, 32'h0000_4000, 32'h0BAD_F00D, 32'h0000_0042);
        tick(1'b0, 8'h00);
        check("post_rst_access", rxwr_access, 1);
        check("post_rst_packet", rxwr_packet, mk_pkt(1'b1, 2'd0, 4'd2, 32'h0000_4000, 32'h0BAD_F00D, 32'h0000_0042));
        tick(1'b0, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
